// File: rtl/tomasulo_reg_status_file.sv
// Register file with per-register busy bit and producer tag, written by the CDB on tag match.
// Optional macro REGFILE_CDB_BYPASS_EN forwards a matching CDB broadcast to the read ports.
module tomasulo_reg_status_file #(
  parameter  int NUM_REGS = 8,
  parameter  int DATA_W   = 16,
  parameter  int TAG_W    = 3,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [IDX_W-1:0]  issue_rd,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [IDX_W-1:0]  rd_addr_a,
  input  logic [IDX_W-1:0]  rd_addr_b,
  output logic              rd_ready_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [TAG_W-1:0]  rd_tag_a,
  output logic              rd_ready_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [TAG_W-1:0]  rd_tag_b,
  output logic [IDX_W:0]    busy_count
);

  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } readResult_t;

  logic [NUM_REGS-1:0][DATA_W-1:0] r_val;
  logic [NUM_REGS-1:0]             r_busy;
  logic [NUM_REGS-1:0][TAG_W-1:0]  r_tag;
  logic [CNT_W-1:0]                r_busyCount;

  logic [NUM_REGS-1:0][DATA_W-1:0] w_valNext;
  logic [NUM_REGS-1:0]             w_busyNext;
  logic [NUM_REGS-1:0][TAG_W-1:0]  w_tagNext;
  logic [CNT_W-1:0]                w_countNext;
  logic                            w_issueInRange;

  assign w_issueInRange = ({1'b0, issue_rd} < CNT_W'(NUM_REGS));

  // CDB clears matching producers first; a same-cycle rename then re-marks its register busy
  always_comb begin
    w_valNext  = r_val;
    w_busyNext = r_busy;
    w_tagNext  = r_tag;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cdb_valid && r_busy[i] && (r_tag[i] == cdb_tag)) begin
        w_valNext[i]  = cdb_data;
        w_busyNext[i] = 1'b0;
      end
    end
    if (issue_valid && w_issueInRange) begin
      w_busyNext[issue_rd] = 1'b1;
      w_tagNext[issue_rd]  = issue_tag;
    end
  end

  always_comb begin
    w_countNext = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_countNext = w_countNext + {{IDX_W{1'b0}}, w_busyNext[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_val       <= '0;
      r_busy      <= '0;
      r_tag       <= '0;
      r_busyCount <= '0;
    end else begin
      r_val       <= w_valNext;
      r_busy      <= w_busyNext;
      r_tag       <= w_tagNext;
      r_busyCount <= w_countNext;
    end
  end

  assign busy_count = r_busyCount;

  logic [IDX_W-1:0] w_rdAddr [2];
  readResult_t      w_rdResult [2];

  assign w_rdAddr[0] = rd_addr_a;
  assign w_rdAddr[1] = rd_addr_b;

  for (genvar p = 0; p < 2; p++) begin : g_readPort
    logic w_inRange;
    assign w_inRange = ({1'b0, w_rdAddr[p]} < CNT_W'(NUM_REGS));

    always_comb begin
      w_rdResult[p] = '{ready: 1'b1, data: '0, tag: '0};
      if (w_inRange) begin
        w_rdResult[p].ready = !r_busy[w_rdAddr[p]];
        w_rdResult[p].data  = r_val[w_rdAddr[p]];
        w_rdResult[p].tag   = r_busy[w_rdAddr[p]] ? r_tag[w_rdAddr[p]] : '0;
`ifdef REGFILE_CDB_BYPASS_EN
        if (cdb_valid && r_busy[w_rdAddr[p]] && (r_tag[w_rdAddr[p]] == cdb_tag)) begin
          w_rdResult[p] = '{ready: 1'b1, data: cdb_data, tag: '0};
        end
`endif
      end
    end
  end

  assign rd_ready_a = w_rdResult[0].ready;
  assign rd_data_a  = w_rdResult[0].data;
  assign rd_tag_a   = w_rdResult[0].tag;
  assign rd_ready_b = w_rdResult[1].ready;
  assign rd_data_b  = w_rdResult[1].data;
  assign rd_tag_b   = w_rdResult[1].tag;

endmodule
